sha256_nonce_scheduler: RTL

Sequencer that owns the `sha256_2_pipeline` double-SHA datapath in the miner. It accepts one work unit at a time: midstate, 96-bit header tail, nonce range and 64-bit target. It issues one nonce per cycle into the pipeline, attributes every `valid_out` result back to its nonce, and reports hits through a one-entry result buffer. It also drains in-flight results on range end or abort before accepting the next job.

---
 rtl/sha256_nonce_scheduler.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sha256_nonce_scheduler.sv
// sha256_nonce_scheduler
// Sequencer in front of the sha256_2_pipeline double-SHA datapath. Takes one
// work unit at a time, streams one nonce per cycle into the pipeline, matches
// each returned digest to its nonce in issue order, and parks hits in a
// one-entry result buffer. A job ends with a drain of all in-flight results.
//
// Optional feature macro: SHA_SCHED_HASH_COUNT_EN
//   When defined, a saturating 32-bit hash_count output counts every digest
//   accepted from the pipeline since reset. When undefined the port and the
//   counter do not exist.

module sha256_nonce_scheduler #(
  parameter int INFLIGHT_W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_midstate,
  input  logic [95:0]  job_tail,
  input  logic [31:0]  job_nonce_start,
  input  logic [31:0]  job_nonce_end,
  input  logic [63:0]  job_target,
  input  logic         abort,
  output logic         sha_write_en,
  output logic [255:0] sha_digest_initial,
  output logic [255:0] sha_digest_in,
  output logic [127:0] sha_block_in,
  input  logic [255:0] sha_digest_out,
  input  logic         sha_valid_out,
  output logic         found_valid,
  input  logic         found_ready,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_digest,
  output logic         found_overflow,
  output logic         busy,
  output logic         done
`ifdef SHA_SCHED_HASH_COUNT_EN
  ,
  output logic [31:0]  hash_count
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [INFLIGHT_W-1:0] INFLIGHT_ONE = INFLIGHT_W'(1);

  // Sequencer state and latched job fields
  logic [1:0]            state_q, state_d;
  logic [255:0]          midstate_q, midstate_d;
  logic [95:0]           tail_q, tail_d;
  logic [31:0]           end_q, end_d;
  logic [63:0]           target_q, target_d;
  logic [31:0]           issue_nonce_q, issue_nonce_d;
  logic                  discard_q, discard_d;

  // Pipeline-side registered outputs
  logic                  sha_write_en_q, sha_write_en_d;
  logic [127:0]          sha_block_in_q, sha_block_in_d;

  // In-flight tracking and result attribution
  logic [INFLIGHT_W-1:0] inflight_q, inflight_d;
  logic [31:0]           result_nonce_q, result_nonce_d;

  // Result buffer
  logic                  found_valid_q, found_valid_d;
  logic [31:0]           found_nonce_q, found_nonce_d;
  logic [255:0]          found_digest_q, found_digest_d;
  logic                  found_overflow_q, found_overflow_d;
  logic                  done_q, done_d;

`ifdef SHA_SCHED_HASH_COUNT_EN
  logic [31:0]           hash_count_q, hash_count_d;
`endif

  // Shared per-cycle events
  logic job_accept;
  logic valid_counted;
  logic is_hit;
  logic pop;

  // Decode the events every other block keys off: job acceptance, a pipeline
  // result that belongs to us, whether that result is a hit, and a buffer pop
  always_comb begin
    job_accept    = (state_q == ST_IDLE) && job_valid;
    valid_counted = sha_valid_out && (inflight_q != '0);
    is_hit        = valid_counted && !discard_q &&
                    (sha_digest_out[255:192] <= target_q);
    pop           = found_valid_q && found_ready;
  end

  // Job sequencing: accept in IDLE, stream nonces in ISSUE, wait out the
  // pipeline in DRAIN. The issue strobe and block are computed one cycle ahead
  // so they leave the block straight from flops.
  always_comb begin
    state_d        = state_q;
    midstate_d     = midstate_q;
    tail_d         = tail_q;
    end_d          = end_q;
    target_d       = target_q;
    issue_nonce_d  = issue_nonce_q;
    discard_d      = discard_q;
    sha_write_en_d = 1'b0;
    sha_block_in_d = sha_block_in_q;
    done_d         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          midstate_d     = job_midstate;
          tail_d         = job_tail;
          end_d          = job_nonce_end;
          target_d       = job_target;
          issue_nonce_d  = job_nonce_start;
          discard_d      = 1'b0;
          sha_write_en_d = 1'b1;
          sha_block_in_d = {job_tail, job_nonce_start};
          state_d        = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (abort) begin
          discard_d = 1'b1;
          state_d   = ST_DRAIN;
        end else if (issue_nonce_q == end_q) begin
          state_d = ST_DRAIN;
        end else begin
          issue_nonce_d  = issue_nonce_q + 32'd1;
          sha_write_en_d = 1'b1;
          sha_block_in_d = {tail_q, issue_nonce_q + 32'd1};
        end
      end

      ST_DRAIN: begin
        if (inflight_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Count issues against returned results; the pipeline is in order, so the
  // oldest outstanding nonce is always the one a result belongs to
  always_comb begin
    inflight_d     = inflight_q;
    result_nonce_d = result_nonce_q;

    case ({sha_write_en_q, valid_counted})
      2'b10:   inflight_d = inflight_q + INFLIGHT_ONE;
      2'b01:   inflight_d = inflight_q - INFLIGHT_ONE;
      default: inflight_d = inflight_q;
    endcase

    if (valid_counted) begin
      result_nonce_d = result_nonce_q + 32'd1;
    end

    if (job_accept) begin
      result_nonce_d = job_nonce_start;
    end
  end

  // One-entry hit buffer: a hit loads it when it is empty or being popped this
  // cycle; otherwise the new hit is dropped and the loss is flagged
  always_comb begin
    found_valid_d    = found_valid_q;
    found_nonce_d    = found_nonce_q;
    found_digest_d   = found_digest_q;
    found_overflow_d = found_overflow_q;

    if (is_hit) begin
      if (!found_valid_q || pop) begin
        found_valid_d  = 1'b1;
        found_nonce_d  = result_nonce_q;
        found_digest_d = sha_digest_out;
      end else begin
        found_overflow_d = 1'b1;
      end
    end else if (pop) begin
      found_valid_d = 1'b0;
    end

    if (job_accept) begin
      found_overflow_d = 1'b0;
    end
  end

`ifdef SHA_SCHED_HASH_COUNT_EN
  // Lifetime count of accepted pipeline results, held at all-ones once full
  always_comb begin
    hash_count_d = hash_count_q;
    if (valid_counted && (hash_count_q != 32'hFFFF_FFFF)) begin
      hash_count_d = hash_count_q + 32'd1;
    end
  end
`endif

  // State registers, cleared asynchronously so a mid-job reset lands in IDLE
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q          <= ST_IDLE;
      midstate_q       <= '0;
      tail_q           <= '0;
      end_q            <= '0;
      target_q         <= '0;
      issue_nonce_q    <= '0;
      discard_q        <= 1'b0;
      sha_write_en_q   <= 1'b0;
      sha_block_in_q   <= '0;
      inflight_q       <= '0;
      result_nonce_q   <= '0;
      found_valid_q    <= 1'b0;
      found_nonce_q    <= '0;
      found_digest_q   <= '0;
      found_overflow_q <= 1'b0;
      done_q           <= 1'b0;
`ifdef SHA_SCHED_HASH_COUNT_EN
      hash_count_q     <= '0;
`endif
    end else begin
      state_q          <= state_d;
      midstate_q       <= midstate_d;
      tail_q           <= tail_d;
      end_q            <= end_d;
      target_q         <= target_d;
      issue_nonce_q    <= issue_nonce_d;
      discard_q        <= discard_d;
      sha_write_en_q   <= sha_write_en_d;
      sha_block_in_q   <= sha_block_in_d;
      inflight_q       <= inflight_d;
      result_nonce_q   <= result_nonce_d;
      found_valid_q    <= found_valid_d;
      found_nonce_q    <= found_nonce_d;
      found_digest_q   <= found_digest_d;
      found_overflow_q <= found_overflow_d;
      done_q           <= done_d;
`ifdef SHA_SCHED_HASH_COUNT_EN
      hash_count_q     <= hash_count_d;
`endif
    end
  end

  assign job_ready          = (state_q == ST_IDLE);
  assign busy               = (state_q != ST_IDLE);
  assign done               = done_q;
  assign sha_write_en       = sha_write_en_q;
  assign sha_block_in       = sha_block_in_q;
  assign sha_digest_initial = midstate_q;
  assign sha_digest_in      = midstate_q;
  assign found_valid        = found_valid_q;
  assign found_nonce        = found_nonce_q;
  assign found_digest       = found_digest_q;
  assign found_overflow     = found_overflow_q;
`ifdef SHA_SCHED_HASH_COUNT_EN
  assign hash_count         = hash_count_q;
`endif

endmodule
